fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Parametrised fetch stage with an instruction prefetch queue.
- Keeps the PC and issues one instruction-memory read at a time over a req/rdy/valid handshake.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode under stall.
- Adds what the single-register fetch lacks: redirect flush with in-flight response drop, interrupt instruction injection, and error tagging.

Parameters:
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
INSTR_BYTES, 4, PC increment per instruction
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
PC_next  in  ADDR_W  redirect target, used when flush=1
flush  in  1  redirect: discard queue and in-flight fetch, PC<=PC_next
stall  in  1  decode not accepting; hold head entry
halt  in  1  stop issuing new fetches (queue still drains)
INT  in  1  interrupt request (level, sampled)
INT_INST  in  INSTR_W  instruction injected on interrupt
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  request address
mem_rdy  in  1  memory accepts request this cycle
mem_valid  in  1  response data valid
mem_data  in  INSTR_W  response instruction
mem_err  in  1  response error
instr  out  INSTR_W  instruction to decode
instr_pc  out  ADDR_W  PC of instr
instr_valid  out  1  instr/instr_pc meaningful
err  out  1  instr carries a memory error
nextInstrAddr  out  ADDR_W  instr_pc + INSTR_BYTES

Behaviour:
- Reset, asynchronous while rst_n=0:
  - PC=RESET_PC; FIFO empty; FSM=IDLE; int_pend=0.
  - mem_req=0; instr_valid=0; instr=0; instr_pc=0; err=0; nextInstrAddr=RESET_PC+INSTR_BYTES.
- FSM states IDLE, REQ, WAIT, DROP:
  - IDLE->REQ when ~halt & ~flush & (count+0)<DEPTH.
  - REQ: mem_req=1, mem_addr=PC. On mem_rdy, go to WAIT and set PC+=INSTR_BYTES (mod 2^ADDR_W, wraps silently).
  - WAIT: on mem_valid, push {PC_of_req, mem_data, mem_err} into FIFO. Then go to REQ if space remains after the push and ~halt, else IDLE.
  - flush in REQ with mem_rdy=0 -> IDLE, no request accepted.
  - flush in REQ with mem_rdy=1, or flush in WAIT without mem_valid -> DROP.
  - flush in WAIT with mem_valid the same cycle -> response discarded, IDLE.
  - DROP: ignore the next mem_valid, then IDLE. A further flush while in DROP stays in DROP and only updates PC.
- At most one request outstanding. mem_req is never asserted when the FIFO would be full on return: count + outstanding <= DEPTH.
- Output path:
  - instr_valid = FIFO non-empty | int_pend. Outputs are combinational from the head.
  - Head pops on cycles with instr_valid & ~stall & ~flush & ~int_pend.
  - A push and a pop in the same cycle keep count unchanged. Push while full is impossible by construction; assert it in simulation.
- Flush:
  - Highest priority. Same-cycle effect: FIFO emptied, PC<=PC_next.
  - instr_valid is forced 0 in the flush cycle.
  - flush wins over stall and over INT presentation.
- Interrupt:
  - INT rising-edge sets int_pend. While int_pend=1: instr=INT_INST, err=0, instr_pc = head PC if the FIFO is non-empty, else the current PC (return address).
  - int_pend clears on a cycle with ~stall & ~flush. The FIFO head is not consumed.
  - INT edge during flush keeps int_pend=1; it is presented the cycle after.
- halt: blocks IDLE->REQ only. In-progress REQ/WAIT complete normally.
- When instr_valid=0, instr/instr_pc/err are driven 0.

Test Plan:
- Reset/linear fetch: RESET_PC=0, mem_rdy=1, mem_valid one cycle after accept with data=0x1000+addr, stall=0 -> instr_pc sequence 0,4,8,12 with instr 0x1000,0x1004,...; nextInstrAddr=instr_pc+4.
- Backpressure: stall=1 for 10 cycles from start -> exactly 4 requests issued (addr 0..12), then mem_req=0. After stall drops, 4 entries drain in order and fetch resumes at 16.
- Flush in WAIT: request for addr 8 accepted; flush=1 with PC_next=0x200 before the response; response for 8 arrives -> dropped. Next instr_pc=0x200 and the FIFO holds nothing from 8.
- Flush colliding with mem_valid and stall in the same cycle -> FIFO empty, instr_valid=0 next cycle, next request addr=PC_next.
- Interrupt: FIFO head pc=0x10; INT pulse with INT_INST=0xDEAD -> one valid cycle with instr=0xDEAD, instr_pc=0x10. The following cycle instr is the original 0x10 entry.
- Error/wrap: PC_next=0xFFFFFFFC, mem_err=1 on the first response -> instr_pc=0xFFFFFFFC with err=1; next request addr=0x0; rst_n pulled low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Fetch stage with a DEPTH-entry instruction prefetch queue, redirect flush with
// in-flight response drop, interrupt instruction injection and error tagging.
module fetch_prefetch #(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        INSTR_W     = 32,
    parameter int unsigned        DEPTH       = 4,
    parameter int unsigned        INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  PC_next,
    input  logic               flush,
    input  logic               stall,
    input  logic               halt,
    input  logic               INT,
    input  logic [INSTR_W-1:0] INT_INST,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rdy,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               mem_err,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               err,
    output logic [ADDR_W-1:0]  nextInstrAddr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  FullCount = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CountOne  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PtrOne    = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PcInc     = ADDR_W'(INSTR_BYTES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDrop = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              int_pend_q, int_pend_d;
    logic              int_prev_q;

    logic [ADDR_W-1:0]  fifo_pc_q   [DEPTH];
    logic [INSTR_W-1:0] fifo_data_q [DEPTH];
    logic               fifo_err_q  [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic int_edge;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);
    assign int_edge   = INT & ~int_prev_q;

    assign instr_valid = (~fifo_empty | int_pend_q) & ~flush;
    // The injected interrupt instruction holds the head in place.
    assign pop  = ~fifo_empty & ~stall & ~flush & ~int_pend_q;
    assign push = (state_q == StWait) & mem_valid & ~flush;

    assign mem_req  = (state_q == StReq);
    assign mem_addr = pc_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            StIdle: begin
                if (~halt & ~flush & ~fifo_full) state_d = StReq;
            end
            StReq: begin
                if (mem_rdy) begin
                    state_d  = flush ? StDrop : StWait;
                    pc_d     = pc_q + PcInc;
                    req_pc_d = pc_q;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (mem_valid) begin
                    if (~flush & ~halt & (count_d < FullCount)) state_d = StReq;
                    else                                        state_d = StIdle;
                end else if (flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (mem_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) pc_d = PC_next;
    end

    always_comb begin
        int_pend_d = int_pend_q;
        if (int_edge)                       int_pend_d = 1'b1;
        else if (int_pend_q & ~stall & ~flush) int_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            int_pend_q <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            int_pend_q <= int_pend_d;
            int_prev_q <= INT;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_data_q[wr_ptr_q] <= mem_data;
            fifo_err_q[wr_ptr_q]  <= mem_err;
        end
    end

    // Request gating keeps count + outstanding <= DEPTH, so this never fires.
    always_ff @(posedge clk) begin
        if (rst_n && push) assert (!fifo_full);
    end

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        err      = 1'b0;
        if (instr_valid) begin
            if (int_pend_q) begin
                instr    = INT_INST;
                instr_pc = fifo_empty ? pc_q : fifo_pc_q[rd_ptr_q];
            end else begin
                instr    = fifo_data_q[rd_ptr_q];
                instr_pc = fifo_pc_q[rd_ptr_q];
                err      = fifo_err_q[rd_ptr_q];
            end
        end
    end

    assign nextInstrAddr = instr_valid ? (instr_pc + PcInc) : (pc_q + PcInc);

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a one-outstanding memory model answers with
// data = 0x1000 + addr after a configurable latency.
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] PC_next = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        INT = 1'b0;
    logic [31:0] INT_INST = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rdy = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic        mem_err = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        err;
    logic [31:0] nextInstrAddr;

    int checks = 0;
    int fails = 0;

    // Memory model state
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          lat = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          req_count = 0;
    logic [31:0] addr_log [64];
    logic        acc_flag = 1'b0;

    fetch_prefetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_next       (PC_next),
        .flush         (flush),
        .stall         (stall),
        .halt          (halt),
        .INT           (INT),
        .INT_INST      (INT_INST),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdy       (mem_rdy),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .mem_err       (mem_err),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .err           (err),
        .nextInstrAddr (nextInstrAddr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle; called at a negedge, returns at the next negedge.
    task automatic tick();
        logic        a;
        logic [31:0] ad;
        a = mem_req && mem_rdy;
        ad = mem_addr;
        acc_flag = a;
        if (a) begin
            if (req_count < 64) addr_log[req_count] = ad;
            req_count++;
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_err = 1'b0;
        if (a) begin
            pend = 1'b1;
            pend_cnt = lat;
            pend_addr = ad;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data = 32'h1000 + pend_addr;
                mem_err = err_en && (pend_addr == err_addr);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        halt = 1'b0;
        INT = 1'b0;
        PC_next = '0;
        pend = 1'b0;
        mem_valid = 1'b0;
        mem_err = 1'b0;
        lat = 0;
        err_en = 1'b0;
        req_count = 0;
        acc_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++; if (mem_req !== 1'b0) begin fails++;
            $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin fails++;
            $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin fails++;
            $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin fails++;
            $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        checks++; if (err !== 1'b0) begin fails++;
            $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (nextInstrAddr !== 32'h4) begin fails++;
            $display("FAIL reset_next_addr: got %h expected 4", nextInstrAddr); end
        do_reset();
    endtask

    task automatic test_linear();
        logic [31:0] exp_pc;
        int n;
        do_reset();
        exp_pc = 0;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            if (instr_valid) begin
                checks++; if (instr_pc !== exp_pc) begin fails++;
                    $display("FAIL linear_pc: got %h expected %h", instr_pc, exp_pc); end
                checks++; if (instr !== 32'h1000 + exp_pc) begin fails++;
                    $display("FAIL linear_instr: got %h expected %h", instr, 32'h1000 + exp_pc); end
                checks++; if (nextInstrAddr !== exp_pc + 4) begin fails++;
                    $display("FAIL linear_next: got %h expected %h", nextInstrAddr, exp_pc + 4); end
                exp_pc += 4;
                n++;
            end
            tick();
        end
        checks++; if (n != 4) begin fails++;
            $display("FAIL linear_count: got %0d expected 4", n); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int n;
        do_reset();
        stall = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        checks++; if (req_count != 4) begin fails++;
            $display("FAIL bp_req_count: got %0d expected 4", req_count); end
        checks++; if (mem_req !== 1'b0) begin fails++;
            $display("FAIL bp_mem_req: got %b expected 0", mem_req); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (addr_log[i] !== 32'(i * 4)) begin fails++;
                $display("FAIL bp_addr: got %h expected %h", addr_log[i], 32'(i * 4)); end
        end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++;
            $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0",
                     instr_valid, instr_pc); end
        stall = 1'b0;
        exp_pc = 0;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            if (instr_valid) begin
                checks++; if (instr_pc !== exp_pc || instr !== 32'h1000 + exp_pc) begin
                    fails++;
                    $display("FAIL bp_drain: got pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr, exp_pc, 32'h1000 + exp_pc);
                end
                exp_pc += 4;
                n++;
            end
            tick();
        end
        checks++; if (n != 5) begin fails++;
            $display("FAIL bp_drain_count: got %0d expected 5", n); end
    endtask

    task automatic test_flush_wait();
        int found;
        int base;
        do_reset();
        lat = 2;
        found = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (acc_flag && addr_log[req_count-1] == 32'h8) begin
                found = 1;
                break;
            end
        end
        checks++; if (found != 1) begin fails++;
            $display("FAIL fw_accept8: got %0d expected 1", found); end
        PC_next = 32'h200;
        flush = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin fails++;
            $display("FAIL fw_flush_valid: got %b expected 0", instr_valid); end
        base = req_count;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 60 && !instr_valid; c++) tick();
        checks++; if (instr_pc !== 32'h200 || instr !== 32'h1200) begin fails++;
            $display("FAIL fw_next: got pc=%h instr=%h expected pc=200 instr=1200",
                     instr_pc, instr); end
        checks++; if (req_count <= base || addr_log[base] !== 32'h200) begin fails++;
            $display("FAIL fw_req_addr: got %h expected 200", addr_log[base]); end
        lat = 0;
    endtask

    task automatic test_flush_collide();
        do_reset();
        stall = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (req_count == 2 && mem_valid) break;
        end
        checks++; if (!(req_count == 2 && mem_valid === 1'b1)) begin fails++;
            $display("FAIL fc_setup: got req_count=%0d valid=%b expected 2/1",
                     req_count, mem_valid); end
        PC_next = 32'h300;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin fails++;
            $display("FAIL fc_empty: got %b expected 0", instr_valid); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (acc_flag) break;
        end
        checks++; if (addr_log[req_count-1] !== 32'h300) begin fails++;
            $display("FAIL fc_req_addr: got %h expected 300", addr_log[req_count-1]); end
        for (int c = 0; c < 20 && !instr_valid; c++) tick();
        checks++; if (instr_pc !== 32'h300 || instr !== 32'h1300) begin fails++;
            $display("FAIL fc_head: got pc=%h instr=%h expected pc=300 instr=1300",
                     instr_pc, instr); end
        stall = 1'b0;
    endtask

    task automatic test_interrupt();
        do_reset();
        PC_next = 32'h10;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b1;
        for (int c = 0; c < 20 && !instr_valid; c++) tick();
        checks++; if (instr_pc !== 32'h10) begin fails++;
            $display("FAIL int_head: got %h expected 10", instr_pc); end
        INT_INST = 32'hDEAD;
        INT = 1'b1;
        tick();
        INT = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD) begin fails++;
            $display("FAIL int_inject: got valid=%b instr=%h expected 1/dead",
                     instr_valid, instr); end
        checks++; if (instr_pc !== 32'h10 || err !== 1'b0) begin fails++;
            $display("FAIL int_pc: got pc=%h err=%b expected 10/0", instr_pc, err); end
        stall = 1'b0;
        tick();
        checks++; if (instr !== 32'h1010 || instr_pc !== 32'h10) begin fails++;
            $display("FAIL int_resume: got instr=%h pc=%h expected 1010/10", instr, instr_pc); end
    endtask

    task automatic test_err_wrap();
        do_reset();
        err_en = 1'b1;
        err_addr = 32'hFFFF_FFFC;
        PC_next = 32'hFFFF_FFFC;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b1;
        for (int c = 0; c < 20 && !instr_valid; c++) tick();
        checks++; if (instr_pc !== 32'hFFFF_FFFC || err !== 1'b1) begin fails++;
            $display("FAIL ew_head: got pc=%h err=%b expected fffffffc/1", instr_pc, err); end
        checks++; if (instr !== 32'h0000_0FFC || nextInstrAddr !== 32'h0) begin fails++;
            $display("FAIL ew_instr: got instr=%h next=%h expected ffc/0", instr, nextInstrAddr); end
        for (int c = 0; c < 20 && req_count < 2; c++) tick();
        checks++; if (req_count < 2 || addr_log[1] !== 32'h0) begin fails++;
            $display("FAIL ew_wrap_addr: got %h expected 0", addr_log[1]); end
        checks++; if (mem_valid !== 1'b1) begin fails++;
            $display("FAIL ew_in_wait: got %b expected 1", mem_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
                      instr_pc !== 32'h0 || err !== 1'b0) begin fails++;
            $display("FAIL ew_async_reset: got req=%b valid=%b instr=%h pc=%h err=%b expected all 0",
                     mem_req, instr_valid, instr, instr_pc, err); end
        do_reset();
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (req_count != 0 || mem_req !== 1'b0) begin fails++;
            $display("FAIL halt_block: got reqs=%0d req=%b expected 0/0", req_count, mem_req); end
        halt = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (acc_flag) break;
        end
        checks++; if (req_count != 1 || addr_log[0] !== 32'h0) begin fails++;
            $display("FAIL halt_resume: got reqs=%0d addr=%h expected 1/0",
                     req_count, addr_log[0]); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_backpressure();
        test_flush_wait();
        test_flush_collide();
        test_interrupt();
        test_err_wrap();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
